// File: rtl/game_round_ctrl.sv
// Round/level sequencer for the rhythm game: MENU/PLAY/PAUSE/WIN/LOSE/EXIT flow,
// per-round hit/miss counters and multi-level progression with a timed WIN hold.
module game_round_ctrl #(
    parameter int CNT_W       = 4,
    parameter int ROUND_NOTES = 10,
    parameter int MISS_LIMIT  = 3,
    parameter int LEVELS      = 4,
    parameter int WIN_HOLD    = 50,
    localparam int LVL_W      = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       cmd,
    input  logic             life_full,
    input  logic             hit,
    input  logic             miss,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] score,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [LVL_W-1:0] level,
    output logic             round_end
);

    localparam int HOLD_W = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;

    localparam logic [2:0]        CMD_START = 3'b010;
    localparam logic [2:0]        CMD_EXIT  = 3'b101;
    localparam logic [2:0]        CMD_PAUSE = 3'b011;
    localparam logic [CNT_W-1:0]  MISS_MAX  = CNT_W'(MISS_LIMIT);
    localparam logic [CNT_W:0]    NOTES     = (CNT_W+1)'(ROUND_NOTES);
    localparam logic [LVL_W-1:0]  LAST_LVL  = LVL_W'(LEVELS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WIN_HOLD - 1);

    typedef enum logic [2:0] {
        S_RESET = 3'b000,
        S_MENU  = 3'b001,
        S_PLAY  = 3'b010,
        S_PAUSE = 3'b011,
        S_WIN   = 3'b100,
        S_EXIT  = 3'b101,
        S_LOSE  = 3'b110
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cmd_q;
    logic [CNT_W-1:0]  score_q, score_d, miss_q, miss_d;
    logic [CNT_W-1:0]  next_score, next_miss;
    logic [CNT_W:0]    note_sum;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              round_end_q, round_end_d;
    logic              cmd_edge, start_edge, exit_edge, pause_edge;

    // Commands only fire on the cycle the decoder output changes.
    assign cmd_edge   = (cmd != cmd_q);
    assign start_edge = cmd_edge && (cmd == CMD_START);
    assign exit_edge  = cmd_edge && (cmd == CMD_EXIT);
    assign pause_edge = cmd_edge && (cmd == CMD_PAUSE);

    assign next_score = (hit  && (score_q != '1)) ? score_q + CNT_W'(1) : score_q;
    assign next_miss  = (miss && (miss_q  != '1)) ? miss_q  + CNT_W'(1) : miss_q;
    assign note_sum   = {1'b0, next_score} + {1'b0, next_miss};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RESET;
            cmd_q       <= 3'b000;
            score_q     <= '0;
            miss_q      <= '0;
            level_q     <= '0;
            hold_q      <= '0;
            round_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd;
            score_q     <= score_d;
            miss_q      <= miss_d;
            level_q     <= level_d;
            hold_q      <= hold_d;
            round_end_q <= round_end_d;
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        miss_d  = miss_q;
        level_d = level_q;
        hold_d  = hold_q;

        case (state_q)
            S_RESET: state_d = S_MENU;
            S_MENU: begin
                if (start_edge && life_full) begin
                    state_d = S_PLAY;
                    score_d = '0;
                    miss_d  = '0;
                end else if (exit_edge) begin
                    state_d = S_EXIT;
                end
            end
            // Loss outranks a win on the same note, and both outrank commands.
            S_PLAY: begin
                score_d = next_score;
                miss_d  = next_miss;
                if (next_miss > MISS_MAX) begin
                    state_d = S_LOSE;
                end else if (note_sum == NOTES) begin
                    state_d = S_WIN;
                    hold_d  = '0;
                end else if (exit_edge) begin
                    state_d = S_EXIT;
                end else if (pause_edge) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (pause_edge)     state_d = S_PLAY;
                else if (exit_edge) state_d = S_EXIT;
            end
            S_WIN: begin
                if (level_q != LAST_LVL) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_PLAY;
                        level_d = level_q + LVL_W'(1);
                        score_d = '0;
                        miss_d  = '0;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end else if (start_edge) begin
                    state_d = S_MENU;
                    level_d = '0;
                end else if (exit_edge) begin
                    state_d = S_EXIT;
                end
            end
            S_LOSE: begin
                if (start_edge) begin
                    state_d = S_MENU;
                    level_d = '0;
                    score_d = '0;
                    miss_d  = '0;
                end else if (exit_edge) begin
                    state_d = S_EXIT;
                end
            end
            S_EXIT:  state_d = S_EXIT;
            default: state_d = S_RESET;
        endcase

        round_end_d = (state_q == S_PLAY) && ((state_d == S_WIN) || (state_d == S_LOSE));
    end

    assign state     = state_q;
    assign score     = score_q;
    assign miss_cnt  = miss_q;
    assign level     = level_q;
    assign round_end = round_end_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: directed vector table, multi-cycle
// sequences and randomized traffic against a rule-level reference model.
module tb_game_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] cmd = 3'b000;
    logic       life_full = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic [2:0] state;
    logic [3:0] score;
    logic [3:0] miss_cnt;
    logic [1:0] level;
    logic       round_end;

    int checks = 0;
    int errors = 0;

    // Reference model, tracked as plain integers following the game rules.
    int m_state, m_score, m_miss, m_level, m_hold, m_cmdq, m_re;

    game_round_ctrl dut (
        .clk(clk), .rst(rst), .cmd(cmd), .life_full(life_full), .hit(hit), .miss(miss),
        .state(state), .score(score), .miss_cnt(miss_cnt), .level(level), .round_end(round_end)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void modelReset();
        m_state = 0; m_score = 0; m_miss = 0; m_level = 0; m_hold = 0; m_cmdq = 0; m_re = 0;
    endfunction

    function automatic void modelStep(int c, int lf, int h, int ms);
        bit fresh;
        bit st;
        bit ex;
        bit pa;
        fresh = (c != m_cmdq);
        st = fresh && (c == 2);
        ex = fresh && (c == 5);
        pa = fresh && (c == 3);
        m_cmdq = c;
        m_re = 0;
        case (m_state)
            0: m_state = 1;
            1: begin
                if (st && lf != 0) begin m_state = 2; m_score = 0; m_miss = 0; end
                else if (ex) m_state = 5;
            end
            2: begin
                m_score = (m_score + h > 15) ? 15 : m_score + h;
                m_miss  = (m_miss + ms > 15) ? 15 : m_miss + ms;
                if (m_miss > 3) begin m_state = 6; m_re = 1; end
                else if (m_score + m_miss == 10) begin m_state = 4; m_hold = 0; m_re = 1; end
                else if (ex) m_state = 5;
                else if (pa) m_state = 3;
            end
            3: begin
                if (pa) m_state = 2;
                else if (ex) m_state = 5;
            end
            4: begin
                if (m_level < 3) begin
                    m_hold++;
                    if (m_hold == 50) begin
                        m_level++; m_score = 0; m_miss = 0; m_state = 2;
                    end
                end else if (st) begin
                    m_state = 1; m_level = 0;
                end else if (ex) m_state = 5;
            end
            6: begin
                if (st) begin m_state = 1; m_level = 0; m_score = 0; m_miss = 0; end
                else if (ex) m_state = 5;
            end
            default: ;
        endcase
    endfunction

    task automatic cmpVal(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic checkOutput(input string tag);
        cmpVal({tag, " state"}, int'(state), m_state);
        cmpVal({tag, " score"}, int'(score), m_score);
        cmpVal({tag, " miss_cnt"}, int'(miss_cnt), m_miss);
        cmpVal({tag, " level"}, int'(level), m_level);
        cmpVal({tag, " round_end"}, int'(round_end), m_re);
    endtask

    task automatic applyStimulus(input int c, input int lf, input int h, input int ms);
        cmd = 3'(c);
        life_full = (lf != 0);
        hit = (h != 0);
        miss = (ms != 0);
        @(posedge clk);
        modelStep(c, lf, h, ms);
        #1;
    endtask

    // Asserted between edges, so the clear must be visible without a clock.
    task automatic doReset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        cmpVal({tag, " state"}, int'(state), 0);
        cmpVal({tag, " score"}, int'(score), 0);
        cmpVal({tag, " miss_cnt"}, int'(miss_cnt), 0);
        cmpVal({tag, " level"}, int'(level), 0);
        cmpVal({tag, " round_end"}, int'(round_end), 0);
        modelReset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        int c; int lf; int h; int ms;
        int st; int sc; int mc; int lv; int re;
    } vec_t;

    vec_t vecs[$];
    int   notes[10];
    int   win_cycles;
    int   cur_cmd;
    int   r;

    initial begin
        // cmd, life_full, hit, miss  ->  state, score, miss_cnt, level, round_end
        vecs.push_back('{0, 0, 0, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{2, 0, 0, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{2, 0, 0, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{2, 0, 0, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{2, 0, 0, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{2, 0, 0, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{2, 1, 0, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{2, 1, 0, 0, 2, 0, 0, 0, 0});
        vecs.push_back('{2, 1, 1, 0, 2, 1, 0, 0, 0});
        vecs.push_back('{3, 1, 0, 0, 3, 1, 0, 0, 0});
        vecs.push_back('{3, 1, 1, 0, 3, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 1, 1, 3, 1, 0, 0, 0});
        vecs.push_back('{3, 1, 0, 0, 2, 1, 0, 0, 0});
        vecs.push_back('{3, 1, 1, 1, 2, 2, 1, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 2, 2, 2, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 2, 2, 3, 0, 0});
        vecs.push_back('{5, 1, 1, 1, 6, 3, 4, 0, 1});
        vecs.push_back('{5, 1, 0, 0, 6, 3, 4, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 6, 3, 4, 0, 0});
        vecs.push_back('{2, 0, 0, 0, 1, 0, 0, 0, 0});

        modelReset();
        #12;
        cmpVal("reset state", int'(state), 0);
        cmpVal("reset score", int'(score), 0);
        cmpVal("reset miss_cnt", int'(miss_cnt), 0);
        cmpVal("reset level", int'(level), 0);
        cmpVal("reset round_end", int'(round_end), 0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].c, vecs[i].lf, vecs[i].h, vecs[i].ms);
            cmpVal($sformatf("vec%0d state", i), int'(state), vecs[i].st);
            cmpVal($sformatf("vec%0d score", i), int'(score), vecs[i].sc);
            cmpVal($sformatf("vec%0d miss_cnt", i), int'(miss_cnt), vecs[i].mc);
            cmpVal($sformatf("vec%0d level", i), int'(level), vecs[i].lv);
            cmpVal($sformatf("vec%0d round_end", i), int'(round_end), vecs[i].re);
        end

        // Full round: 7 hits + 3 misses, then the timed WIN hold into level 1.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(2, 1, 0, 0);
        cmpVal("round start state", int'(state), 2);
        notes = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(2, 1, notes[i], 1 - notes[i]);
            checkOutput($sformatf("note%0d", i));
        end
        cmpVal("win state", int'(state), 4);
        cmpVal("win round_end", int'(round_end), 1);
        cmpVal("win score", int'(score), 7);
        cmpVal("win miss_cnt", int'(miss_cnt), 3);
        win_cycles = 1;
        while (state == 3'b100 && win_cycles < 200) begin
            applyStimulus(2, 1, 0, 0);
            checkOutput("win hold");
            if (state == 3'b100) win_cycles++;
        end
        cmpVal("win hold length", win_cycles, 50);
        cmpVal("advance state", int'(state), 2);
        cmpVal("advance level", int'(level), 1);
        cmpVal("advance score", int'(score), 0);
        cmpVal("advance miss_cnt", int'(miss_cnt), 0);

        // Four misses lose the round; start from LOSE returns to MENU at level 0.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2, 1, 0, 1);
            cmpVal("miss run state", int'(state), 2);
        end
        applyStimulus(2, 1, 0, 1);
        cmpVal("lose state", int'(state), 6);
        cmpVal("lose round_end", int'(round_end), 1);
        cmpVal("lose miss_cnt", int'(miss_cnt), 4);
        cmpVal("lose level kept", int'(level), 1);
        applyStimulus(0, 1, 1, 0);
        cmpVal("lose frozen score", int'(score), 0);
        applyStimulus(2, 1, 0, 0);
        cmpVal("lose to menu state", int'(state), 1);
        cmpVal("lose to menu level", int'(level), 0);

        // EXIT is terminal.
        applyStimulus(5, 1, 0, 0);
        cmpVal("menu exit state", int'(state), 5);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(2, 1, 0, 0);
        cmpVal("exit terminal state", int'(state), 5);

        // Reset in the middle of a round drops everything at once.
        doReset("exit reset");
        applyStimulus(0, 1, 0, 0);
        applyStimulus(2, 1, 0, 0);
        applyStimulus(2, 1, 1, 0);
        applyStimulus(2, 1, 1, 1);
        checkOutput("pre reset");
        doReset("mid round reset");

        cur_cmd = 0;
        for (int n = 0; n < 4000; n++) begin
            if (m_state == 5 && $urandom_range(0, 9) == 0) doReset("random reset");
            if ($urandom_range(0, 99) >= 85) begin
                r = int'($urandom_range(0, 19));
                if (r < 7) cur_cmd = 0;
                else if (r < 13) cur_cmd = 2;
                else if (r < 18) cur_cmd = 3;
                else if (r == 18) cur_cmd = int'($urandom_range(0, 7));
                else cur_cmd = 5;
            end
            applyStimulus(cur_cmd, ($urandom_range(0, 9) != 0) ? 1 : 0,
                          ($urandom_range(0, 9) < 6) ? 1 : 0,
                          ($urandom_range(0, 19) == 0) ? 1 : 0);
            checkOutput("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
